interval_meter_ms: RTL and testbench

//  Measures elapsed time between a Start event and a Stop event in whole milliseconds.
//  It is the measuring counterpart of the ms delay generator: it takes events and returns N ms.

---
 rtl/fcu_timer_pkg.sv | 18 +
 rtl/ms_tick_gen.sv | 37 +++
 rtl/interval_meter_ms.sv | 127 ++++++++++++
 tb/tb_interval_meter_ms.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fcu_timer_pkg.sv
// Shared FCU timer definitions: FSM state encoding and the 1 ms prescaler constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   tmr_state_t  2-bit state encoding IDLE / RUN / HOLD
//   T1MS_50MHZ   prescaler terminal count for 1 ms at 50 MHz (shared with the delay generator)
package fcu_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } tmr_state_t;

    localparam logic [15:0] T1MS_50MHZ = 16'd49_999;

endpackage

// File: rtl/ms_tick_gen.sv
// Sub-millisecond prescaler: emits a 1-cycle tick every TC+1 enabled cycles.
// Latency: tick is combinational on the cycle the count sits at TC; wrap happens on that edge.
// Backpressure: none; clr has priority, and the count is held at 0 while en is low.
//
// Ports:
//   CLK   in  system clock
//   RSTn  in  asynchronous active-low reset
//   clr   in  synchronous clear of the prescaler
//   en    in  count enable; low forces the prescaler to 0
//   tick  out high on the cycle the prescaler wraps
module ms_tick_gen
    import fcu_timer_pkg::*;
#(
    parameter logic [15:0] TC = T1MS_50MHZ
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [15:0] pre_cnt;

    assign tick = en && (pre_cnt == TC);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt <= 16'd0;
        end else if (clr || !en || tick) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/interval_meter_ms.sv
// Measures whole milliseconds between a Start pulse and a Stop pulse, saturating at all-ones.
// Latency: Ms/Ovf/Valid update on the edge that samples Stop (visible one cycle after Stop).
// Backpressure: the result is held with Valid until Ack; Start is ignored while holding unless paired with Ack.
//
// Ports:
//   CLK    in   system clock
//   RSTn   in   asynchronous active-low reset
//   Start  in   begin or restart a measurement (1-cycle pulse)
//   Stop   in   end the measurement and capture the result (1-cycle pulse)
//   Ack    in   consumer has taken the result; releases Valid
//   Busy   out  measuring
//   Valid  out  Ms/Ovf hold a captured result
//   Ms     out  measured whole ms, saturating
//   Ovf    out  measurement saturated
module interval_meter_ms
    import fcu_timer_pkg::*;
#(
    parameter logic [15:0] T1MS_VAL = T1MS_50MHZ,
    parameter int          MS_W     = 16
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            Start,
    input  logic            Stop,
    input  logic            Ack,
    output logic            Busy,
    output logic            Valid,
    output logic [MS_W-1:0] Ms,
    output logic            Ovf
);

    localparam logic [MS_W-1:0] MS_MAX = '1;

    tmr_state_t      state, state_nxt;
    logic            cnt_clr;       // entering (or re-entering) RUN: clear counters
    logic            capture;       // Stop sampled in RUN: latch result
    logic            tick;
    logic [MS_W-1:0] ms_cnt, ms_nxt, ms_q;
    logic            ovf_flg, ovf_nxt, ovf_q;

    ms_tick_gen #(
        .TC (T1MS_VAL)
    ) u_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .clr  (cnt_clr),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; Stop beats Start in RUN, Ack+Start in HOLD goes straight back to RUN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Start) state_nxt = ST_RUN;
            ST_RUN:  if (Stop)  state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (Ack && Start) state_nxt = ST_RUN;
                else if (Ack)     state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        Busy    = (state == ST_RUN);
        Valid   = (state == ST_HOLD);
        capture = (state == ST_RUN) && Stop;
        cnt_clr = ((state == ST_IDLE) && Start) ||
                  ((state == ST_RUN)  && Start && !Stop) ||
                  ((state == ST_HOLD) && Ack && Start);
    end

    // Next ms count including this cycle's tick, so a Stop coinciding with a wrap counts it.
    // Ovf marks a tick that arrived with the counter already at all-ones.
    always_comb begin
        ms_nxt  = ms_cnt;
        ovf_nxt = ovf_flg;
        if (tick) begin
            if (ms_cnt == MS_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                ms_nxt = ms_cnt + MS_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ms_cnt  <= '0;
            ovf_flg <= 1'b0;
        end else if (cnt_clr) begin
            ms_cnt  <= '0;
            ovf_flg <= 1'b0;
        end else if (state == ST_RUN) begin
            ms_cnt  <= ms_nxt;
            ovf_flg <= ovf_nxt;
        end
    end

    // Result registers: Ms keeps its last value until the next capture; Ovf drops on entry to RUN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ms_q  <= '0;
            ovf_q <= 1'b0;
        end else if (capture) begin
            ms_q  <= ms_nxt;
            ovf_q <= ovf_nxt;
        end else if (cnt_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign Ms  = ms_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_interval_meter_ms.sv
module tb_interval_meter_ms;

    localparam int TC   = 10;   // T1MS_VAL + 1
    localparam int MSW  = 4;
    localparam int MAXV = 15;

    logic           CLK   = 1'b0;
    logic           RSTn  = 1'b0;
    logic           Start = 1'b0;
    logic           Stop  = 1'b0;
    logic           Ack   = 1'b0;
    logic           Busy, Valid, Ovf;
    logic [MSW-1:0] Ms;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ms;
        bit ovf;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    interval_meter_ms #(
        .T1MS_VAL (16'd9),
        .MS_W     (MSW)
    ) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .Start (Start),
        .Stop  (Stop),
        .Ack   (Ack),
        .Busy  (Busy),
        .Valid (Valid),
        .Ms    (Ms),
        .Ovf   (Ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: E edges between Start and Stop sampling -> whole ms, saturating
    function automatic exp_t model(input int e);
        exp_t r;
        int   whole;
        whole = e / TC;
        r.ovf = (whole > MAXV);
        r.ms  = r.ovf ? MAXV : whole;
        return r;
    endfunction

    // gap: cycles from Start to Stop; rs: restart offset (0 = none);
    // ss: Start together with Stop; as: Ack together with the first Start; cs: check right after Start
    task automatic run_meas(input int gap, input int rs, input bit ss, input bit as, input bit cs);
        Start = 1'b1;
        Ack   = as;
        tick();
        Start = 1'b0;
        Ack   = 1'b0;
        if (cs) begin
            chk("busy_after_start", Busy, 1);
            chk("valid_after_start", Valid, 0);
            chk("ovf_cleared_on_start", Ovf, 0);
        end
        for (int i = 1; i < gap; i++) begin
            if (i == rs) Start = 1'b1;
            tick();
            Start = 1'b0;
        end
        Stop  = 1'b1;
        Start = ss;
        sb.push_back(model((rs > 0) ? gap - rs : gap));
        tick();
        Stop  = 1'b0;
        Start = 1'b0;
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) tick();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("valid_after_ack", Valid, 0);
        chk("busy_after_ack", Busy, 0);
    endtask

    // Monitor: every new result presented with Valid is compared against the scoreboard
    initial begin
        exp_t e;
        bit   pv;
        pv = 1'b0;
        forever begin
            @(negedge CLK);
            if (Valid && !pv) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got Ms=%0d with nothing expected", Ms);
                end else begin
                    e = sb.pop_front();
                    chk("ms", Ms, e.ms);
                    chk("ovf", Ovf, e.ovf);
                    chk("busy_in_hold", Busy, 0);
                end
            end
            pv = Valid;
        end
    end

    initial begin
        int gap, rs;
        bit ss, as, in_hold;

        // Reset values
        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_ms", Ms, 0);
        chk("rst_ovf", Ovf, 0);
        RSTn = 1'b1;
        tick();
        tick();

        // Basic measure, result held without Ack
        run_meas(35, 0, 0, 0, 0);
        repeat (20) tick();
        chk("valid_held", Valid, 1);
        chk("ms_held", Ms, 3);
        do_ack(0);

        // Short interval, then exact boundary with Start/Stop ignored in HOLD
        run_meas(9, 0, 0, 0, 0);
        do_ack(2);
        run_meas(10, 0, 0, 0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Stop  = 1'b1;
        tick();
        Stop  = 1'b0;
        chk("hold_ignores_start_valid", Valid, 1);
        chk("hold_ignores_start_busy", Busy, 0);
        chk("hold_ms_stable", Ms, 1);
        do_ack(0);

        // Saturation, then the next Start clears Ovf
        run_meas(200, 0, 0, 0, 0);
        do_ack(3);
        run_meas(25, 0, 0, 0, 1);
        do_ack(1);

        // Start+Stop in RUN captures without restart
        run_meas(47, 0, 1, 0, 0);
        do_ack(0);

        // Stop / Ack in IDLE do nothing
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        Ack  = 1'b1;
        tick();
        Ack  = 1'b0;
        tick();
        chk("idle_busy", Busy, 0);
        chk("idle_valid", Valid, 0);

        // Ack+Start in HOLD goes straight to RUN
        run_meas(15, 0, 0, 0, 0);
        run_meas(23, 0, 0, 1, 1);
        do_ack(0);

        // Restart mid-RUN
        run_meas(60, 25, 0, 0, 0);
        do_ack(0);

        // Reset mid-RUN
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (17) tick();
        RSTn = 1'b0;
        #2;
        chk("rst_run_busy", Busy, 0);
        chk("rst_run_ms", Ms, 0);
        RSTn = 1'b1;
        tick();

        // Reset mid-HOLD after a saturated result
        run_meas(190, 0, 0, 0, 0);
        repeat (2) tick();
        RSTn = 1'b0;
        #2;
        chk("rst_hold_valid", Valid, 0);
        chk("rst_hold_ms", Ms, 0);
        chk("rst_hold_ovf", Ovf, 0);
        RSTn = 1'b1;
        tick();

        // Randomized measurements
        in_hold = 1'b0;
        for (int n = 0; n < 25; n++) begin
            gap = $urandom_range(1, 230);
            rs  = 0;
            if (gap > 1 && $urandom_range(0, 3) == 0) rs = $urandom_range(1, gap - 1);
            ss  = ($urandom_range(0, 3) == 0);
            as  = in_hold && ($urandom_range(0, 1) == 1);
            if (in_hold && !as) do_ack($urandom_range(0, 5));
            run_meas(gap, rs, ss, as, 1'b1);
            in_hold = 1'b1;
        end
        do_ack(0);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
